// File: rtl/logic_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating y = ~a & (~(b&c) | d) on WIDTH lanes, optional complement per beat.
// Optional feature: define LOGIC_EVAL_ONES_EN to add the registered popcount output out_ones.
module logic_eval_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] res_cnt
`ifdef LOGIC_EVAL_ONES_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] t2_q;
  logic [WIDTH-1:0] t1_q;
  logic [WIDTH-1:0] d_q;
  logic             mode_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_next;
  logic             s1_adv;
  logic             s2_adv;

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_y     = y_q;

  assign y_next = (t2_q & (t1_q | d_q)) ^ {WIDTH{mode_q}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      t2_q     <= '0;
      t1_q     <= '0;
      d_q      <= '0;
      mode_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        t2_q   <= ~in_a;
        t1_q   <= ~(in_b & in_c);
        d_q    <= in_d;
        mode_q <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y_q      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y_q <= y_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

`ifdef LOGIC_EVAL_ONES_EN
  localparam int OW = $clog2(WIDTH + 1);

  logic [OW-1:0] ones_next;
  logic [OW-1:0] ones_q;

  always_comb begin
    ones_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_next = ones_next + OW'(y_next[i]);
    end
  end

  // Loaded alongside y_q so the count always describes the presented result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else if (s2_adv && s1_valid) begin
      ones_q <= ones_next;
    end
  end

  assign out_ones = ones_q;
`endif

endmodule

// File: tb/tb_logic_eval_pipe.sv
// Self-checking bench for logic_eval_pipe: directed vectors, backpressure, counter wrap and random handshakes.
module tb_logic_eval_pipe;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b, in_c, in_d;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] res_cnt;
`ifdef LOGIC_EVAL_ONES_EN
  logic [2:0]       out_ones;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [3:0] sb[$];
  logic [3:0] seen[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_y = '0;
  logic       feed_done;

  logic_eval_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_c(in_c),
    .in_d(in_d),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .res_cnt(res_cnt)
`ifdef LOGIC_EVAL_ONES_EN
    ,
    .out_ones(out_ones)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d,
                                       input logic m);
    return (~a & (~(b & c) | d)) ^ {4{m}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic m);
    in_a = a; in_b = b; in_c = c; in_d = d; in_mode = m;
    in_valid = 1'b1;
  endtask

  // Presents one beat and holds it until the pipeline accepts it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic m);
    int n;
    setBeat(a, b, c, d, m);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("in_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard plus stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_y", 32'(out_y), 32'(prev_y));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_extra", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_y", 32'(out_y), 32'(e));
        end
        seen.push_back(out_y);
        pops++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_c, in_d, in_mode));
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
    end
  end

  initial begin
    logic [3:0] bp_exp[5];
    int pops0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_mode = 1'b0;
    feed_done = 1'b0;
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_y", 32'(out_y), 32'd0);
    checkOutput("rst_res_cnt", 32'(res_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_EVAL_ONES_EN
    checkOutput("rst_ones", 32'(out_ones), 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    $display("[TB] reset with beats in flight");
    out_ready = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("pre_rst_cnt", 32'(res_cnt), 32'd1);
    out_ready = 1'b0;
    applyStimulus(4'b1000, 4'b0110, 4'b0100, 4'b0001, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(res_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("no_stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] truth vector");
    applyStimulus(4'b1000, 4'b0110, 4'b0100, 4'b0001, 1'b0);
    checkOutput("lat_early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("truth_y", 32'(out_y), 32'b0011);
`ifdef LOGIC_EVAL_ONES_EN
    checkOutput("truth_ones", 32'(out_ones), 32'd2);
`endif
    applyStimulus(4'b1000, 4'b0110, 4'b0100, 4'b0001, 1'b1);
    tick();
    checkOutput("truth_inv_y", 32'(out_y), 32'b1100);
`ifdef LOGIC_EVAL_ONES_EN
    checkOutput("truth_inv_ones", 32'(out_ones), 32'd2);
`endif
    tick();
    checkOutput("truth_cnt", 32'(res_cnt), 32'd2);

    $display("[TB] legacy vectors back-to-back");
    setBeat(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    setBeat(4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    tick();
    checkOutput("leg0_y", 32'(out_y), 32'b1111);
    checkOutput("leg_ready", 32'(in_ready), 32'd1);
    setBeat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    tick();
    checkOutput("leg1_y", 32'(out_y), 32'b1111);
    setBeat(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("leg2_y", 32'(out_y), 32'b1110);
    in_valid = 1'b0;
    tick();
    checkOutput("leg3_y", 32'(out_y), 32'b1110);
    checkOutput("leg3_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("leg_end_valid", 32'(out_valid), 32'd0);
    checkOutput("leg_cnt", 32'(res_cnt), 32'd6);

    $display("[TB] backpressure");
    seen.delete();
    bp_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100};
    fork
      begin
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      begin
        out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
          checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
          checkOutput("bp_y", 32'(out_y), 32'b1110);
          if (i < 2) tick();
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) checkOutput("bp_order", 32'(seen[i]), 32'(bp_exp[i]));
    end
    checkOutput("bp_cnt", 32'(res_cnt), 32'd11);

    $display("[TB] counter wrap");
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    waitDrain();
    checkOutput("wrap_255", 32'(res_cnt), 32'd255);
    applyStimulus(4'b1010, 4'b0101, 4'b1100, 4'b0011, 1'b0);
    waitDrain();
    checkOutput("wrap_0", 32'(res_cnt), 32'd0);

    $display("[TB] random handshakes");
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            in_a = 4'($urandom); in_b = 4'($urandom);
            in_c = 4'($urandom); in_d = 4'($urandom);
            tick();
          end
          applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        feed_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!feed_done && n < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("rand_pops", 32'(pops - pops0), 32'd1000);
    checkOutput("rand_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("rand_cnt", 32'(res_cnt), 32'd232);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
